// File: rtl/qpsk_tx_framer.sv
// Frame scheduler for the QPSK modulator: preamble, sync word, length byte and
// payload symbols, one symbol per modulator period, with a one-byte fetch buffer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | idle carrier, waiting for start
// S_PRE    | alternating 00/10 preamble symbols
// S_SYNC   | sync word, MSB pair first, 8 symbols
// S_LEN    | latched frame length byte, 4 symbols
// S_PAY    | payload bytes, 4 symbols each, fed from the byte buffer
module qpsk_tx_framer #(
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] SYNC_WORD    = 16'hA5C3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] frame_len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       mod_req,
    output logic [1:0] symbol_in,
    output logic       symbol_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SYNC = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

    logic [2:0] state,      state_n;
    logic [7:0] sym_idx,    sym_idx_n;
    logic [7:0] len_q,      len_q_n;
    logic [7:0] fetched,    fetched_n;
    logic [7:0] sent,       sent_n;
    logic [7:0] buf_q,      buf_q_n;
    logic       buf_full,   buf_full_n;
    logic [7:0] shift_q,    shift_q_n;
    logic [1:0] symbol_in_n;
    logic       symbol_en_n;
    logic       busy_n;
    logic       done_n;
    logic       underrun_n;
    logic       byte_ready_n;

    logic       xfer;
    logic [7:0] sym_idx_inc;
    logic [3:0] sync_pos;

    assign xfer        = byte_valid && byte_ready;
    assign sym_idx_inc = sym_idx + 8'd1;
    // bit position of the low bit of the next sync symbol
    assign sync_pos    = 4'd14 - {sym_idx_inc[2:0], 1'b0};

    always_comb begin
        state_n     = state;
        sym_idx_n   = sym_idx;
        len_q_n     = len_q;
        fetched_n   = fetched;
        sent_n      = sent;
        buf_q_n     = buf_q;
        buf_full_n  = buf_full;
        shift_q_n   = shift_q;
        symbol_in_n = symbol_in;
        symbol_en_n = symbol_en;
        done_n      = 1'b0;
        underrun_n  = 1'b0;

        if (xfer) begin
            buf_q_n    = byte_data;
            buf_full_n = 1'b1;
            fetched_n  = fetched + 8'd1;
        end

        if (abort) begin
            state_n     = S_IDLE;
            sym_idx_n   = 8'd0;
            fetched_n   = 8'd0;
            sent_n      = 8'd0;
            buf_full_n  = 1'b0;
            shift_q_n   = 8'd0;
            symbol_in_n = 2'b00;
            symbol_en_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n     = S_PRE;
                        sym_idx_n   = 8'd0;
                        len_q_n     = frame_len;
                        fetched_n   = 8'd0;
                        sent_n      = 8'd0;
                        buf_full_n  = 1'b0;
                        symbol_in_n = 2'b00;
                        symbol_en_n = 1'b1;
                    end
                end
                S_PRE: begin
                    if (mod_req) begin
                        if (sym_idx == PRE_LAST) begin
                            state_n     = S_SYNC;
                            sym_idx_n   = 8'd0;
                            symbol_in_n = SYNC_WORD[15:14];
                        end else begin
                            sym_idx_n   = sym_idx_inc;
                            symbol_in_n = sym_idx_inc[0] ? 2'b10 : 2'b00;
                        end
                    end
                end
                S_SYNC: begin
                    if (mod_req) begin
                        if (sym_idx == 8'd7) begin
                            state_n     = S_LEN;
                            sym_idx_n   = 8'd0;
                            shift_q_n   = len_q;
                            symbol_in_n = len_q[7:6];
                        end else begin
                            sym_idx_n   = sym_idx_inc;
                            symbol_in_n = SYNC_WORD[sync_pos +: 2];
                        end
                    end
                end
                S_LEN, S_PAY: begin
                    if (mod_req) begin
                        if (sym_idx != 8'd3) begin
                            sym_idx_n   = sym_idx_inc;
                            shift_q_n   = {shift_q[5:0], 2'b00};
                            symbol_in_n = shift_q[5:4];
                        end else if (sent == len_q) begin
                            state_n     = S_IDLE;
                            sym_idx_n   = 8'd0;
                            buf_full_n  = 1'b0;
                            symbol_in_n = 2'b00;
                            symbol_en_n = 1'b0;
                            done_n      = 1'b1;
                        end else if (buf_full) begin
                            // a byte handshaking this very cycle is not yet in buf_full
                            state_n     = S_PAY;
                            sym_idx_n   = 8'd0;
                            shift_q_n   = buf_q;
                            symbol_in_n = buf_q[7:6];
                            buf_full_n  = 1'b0;
                            sent_n      = sent + 8'd1;
                        end else begin
                            state_n     = S_IDLE;
                            sym_idx_n   = 8'd0;
                            buf_full_n  = 1'b0;
                            symbol_in_n = 2'b00;
                            symbol_en_n = 1'b0;
                            underrun_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n     = S_IDLE;
                    sym_idx_n   = 8'd0;
                    buf_full_n  = 1'b0;
                    symbol_in_n = 2'b00;
                    symbol_en_n = 1'b0;
                end
            endcase
        end

        busy_n       = (state_n != S_IDLE);
        byte_ready_n = busy_n && !buf_full_n && (fetched_n < len_q_n);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            sym_idx    <= 8'd0;
            len_q      <= 8'd0;
            fetched    <= 8'd0;
            sent       <= 8'd0;
            buf_q      <= 8'd0;
            buf_full   <= 1'b0;
            shift_q    <= 8'd0;
            symbol_in  <= 2'b00;
            symbol_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            byte_ready <= 1'b0;
        end else begin
            state      <= state_n;
            sym_idx    <= sym_idx_n;
            len_q      <= len_q_n;
            fetched    <= fetched_n;
            sent       <= sent_n;
            buf_q      <= buf_q_n;
            buf_full   <= buf_full_n;
            shift_q    <= shift_q_n;
            symbol_in  <= symbol_in_n;
            symbol_en  <= symbol_en_n;
            busy       <= busy_n;
            done       <= done_n;
            underrun   <= underrun_n;
            byte_ready <= byte_ready_n;
        end
    end

endmodule

// File: tb/tb_qpsk_tx_framer.sv
// Bench for qpsk_tx_framer: frames are checked symbol by symbol against an
// expected symbol list built from the framing rules, with random pacing and byte supply.
module tb_qpsk_tx_framer;

    localparam int PL = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, mod_req, byte_valid;
    logic [7:0] frame_len, byte_data;
    logic       byte_ready, symbol_en, busy, done, underrun;
    logic [1:0] symbol_in;

    qpsk_tx_framer #(.PREAMBLE_LEN(PL), .SYNC_WORD(16'hA5C3)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .frame_len(frame_len), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mod_req(mod_req), .symbol_in(symbol_in),
        .symbol_en(symbol_en), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] pay [256];
    int nidx, avail, vpct, hs_cnt;
    int exp_sym [0:1100];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick(input bit mr, input bit st, input bit ab);
        bit hs;
        @(negedge clk);
        mod_req    = mr;
        start      = st;
        abort      = ab;
        byte_valid = (nidx < avail) && ($urandom_range(99) < vpct);
        byte_data  = byte_valid ? pay[nidx] : 8'($urandom);
        hs         = byte_valid && byte_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            nidx++;
            hs_cnt++;
        end
    endtask

    task automatic check_idle(input string tag, input bit exp_done, input bit exp_unr);
        check({tag, "_en"}, symbol_en, 0);
        check({tag, "_sym"}, symbol_in, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_underrun"}, underrun, exp_unr);
        check({tag, "_ready"}, byte_ready, 0);
    endtask

    // Runs one frame; abort_sym/reset_sym pick a symbol during which to abort or reset.
    task automatic run_frame(input int len, input int av, input int gmin, input int gmax,
                             input int vp, input int abort_sym, input int reset_sym,
                             input bit end_start);
        int total, gap, hs_before, loaded, b, sw;
        bit bnd, last;
        total  = PL + 12 + 4 * len;
        sw     = 'hA5C3;
        for (int k = 0; k < PL; k++) exp_sym[k] = (k % 2 == 1) ? 2 : 0;
        for (int j = 0; j < 8; j++) exp_sym[PL + j] = (sw >> (14 - 2 * j)) & 3;
        for (int j = 0; j < 4; j++) exp_sym[PL + 8 + j] = (len >> (6 - 2 * j)) & 3;
        for (int i = 0; i < len; i++)
            for (int j = 0; j < 4; j++)
                exp_sym[PL + 12 + 4 * i + j] = (int'(pay[i]) >> (6 - 2 * j)) & 3;

        nidx = 0; avail = av; vpct = vp; hs_cnt = 0; loaded = 0;
        frame_len = 8'(len);
        tick(0, 1, 0);
        frame_len = 8'($urandom);
        check("start_en", symbol_en, 1);
        check("start_busy", busy, 1);
        check("start_sym", symbol_in, exp_sym[0]);

        for (int n = 0; n < total; n++) begin
            gap = $urandom_range(gmax, gmin) - 1;
            for (int g = 0; g < gap; g++) begin
                if (n == abort_sym && g == gap / 2) begin
                    tick(0, 0, 1);
                    check_idle("abort", 0, 0);
                    return;
                end
                if (n == reset_sym && g == gap / 2) begin
                    @(negedge clk);
                    #2 reset = 1'b0;
                    #1;
                    check("rst_en", symbol_en, 0);
                    check("rst_sym", symbol_in, 0);
                    check("rst_busy", busy, 0);
                    check("rst_ready", byte_ready, 0);
                    check("rst_done", done, 0);
                    check("rst_underrun", underrun, 0);
                    tick(0, 0, 0);
                    tick(0, 0, 0);
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
                tick(0, 0, 0);
                check("hold_sym", symbol_in, exp_sym[n]);
                check("hold_en", symbol_en, 1);
                check("hold_ready", byte_ready, (hs_cnt == loaded) && (hs_cnt < len));
            end
            hs_before = hs_cnt;
            last = (n == total - 1);
            tick(1, last && end_start, 0);
            if (last) begin
                check_idle("end", 1, 0);
                return;
            end
            bnd = (n + 1 >= PL + 12) && ((n + 1 - PL - 12) % 4 == 0);
            b   = (n + 1 - PL - 12) / 4;
            if (bnd && hs_before <= b) begin
                check_idle("unr", 0, 1);
                return;
            end
            if (bnd) loaded++;
            check("adv_sym", symbol_in, exp_sym[n + 1]);
            check("adv_en", symbol_en, 1);
            check("adv_done", done, 0);
            check("adv_underrun", underrun, 0);
            check("adv_ready", byte_ready, (hs_cnt == loaded) && (hs_cnt < len));
        end
    endtask

    initial begin
        reset = 1'b0; start = 0; abort = 0; mod_req = 0; byte_valid = 0;
        frame_len = 0; byte_data = 0;
        nidx = 0; avail = 0; vpct = 0; hs_cnt = 0;
        #12;
        check_idle("reset", 0, 0);
        @(negedge clk);
        reset = 1'b1;

        tick(1, 0, 0);
        check("idle_modreq_busy", busy, 0);
        tick(1, 1, 1);
        check("start_abort_busy", busy, 0);

        // normal frame
        pay[0] = 8'h1B; pay[1] = 8'hE4;
        run_frame(2, 2, 100, 100, 100, -1, -1, 0);
        tick(0, 0, 0);
        check("post_done", done, 0);

        // zero length with start on the final mod_req, then one cycle later
        run_frame(0, 0, 10, 10, 100, -1, -1, 1);
        check("end_start_busy", busy, 0);
        frame_len = 0;
        tick(0, 1, 0);
        check("late_start_busy", busy, 1);
        check("late_start_ready", byte_ready, 0);
        tick(0, 0, 1);
        check_idle("late_abort", 0, 0);

        // underrun
        for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
        run_frame(3, 1, 8, 8, 100, -1, -1, 0);

        // abort in sync symbol 3, then fresh byte
        for (int i = 0; i < 2; i++) pay[i] = 8'($urandom);
        run_frame(2, 2, 10, 10, 100, PL + 3, -1, 0);
        pay[0] = ~pay[0];
        run_frame(1, 1, 10, 10, 100, -1, -1, 0);

        // random pacing and byte supply
        for (int f = 0; f < 5; f++) begin
            int l;
            l = $urandom_range(6, 0);
            for (int i = 0; i < l; i++) pay[i] = 8'($urandom);
            run_frame(l, l, 3, 40, 40, -1, -1, 0);
            tick(0, 0, 0);
        end
        pay[0] = 8'($urandom);
        run_frame(1, 1, 3, 200, 30, -1, -1, 0);

        // async reset in payload, then a clean frame
        for (int i = 0; i < 2; i++) pay[i] = 8'($urandom);
        run_frame(2, 2, 5, 20, 100, -1, PL + 14, 0);
        for (int i = 0; i < 2; i++) pay[i] = 8'($urandom);
        run_frame(2, 2, 5, 20, 100, -1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qpsk_tx_framer.md
Name: qpsk_tx_framer

Overview:
Frame scheduler that sequences the QPSK modulator's symbol interface. On a start pulse it emits the following, one symbol per modulator symbol period, paced by mod_req:
- preamble
- 16-bit sync word
- length byte
- payload bytes pulled over a valid/ready byte stream

It drives symbol_in/symbol_en of qpsk_modulator and returns to idle carrier when the frame ends, on abort, or on payload underrun.

Parameters:
PREAMBLE_LEN, 32, number of preamble symbols (1..255); alternating 2'b00, 2'b10, starting with 2'b00.
SYNC_WORD, 16'hA5C3, sync word sent MSB first as 8 symbols.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle frame start request; honoured only in IDLE
abort  input  1  synchronous abort; any state -> IDLE
frame_len  input  8  payload length in bytes, latched on accepted start; 0 is legal
byte_data  input  8  payload byte
byte_valid  input  1  byte_data valid
byte_ready  output  1  framer can accept a byte
mod_req  input  1  modulator pulse: current symbol period has ended
symbol_in  output  2  symbol to modulator (bits[7:6] of a byte first)
symbol_en  output  1  high while a frame symbol is presented
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at normal frame end
underrun  output  1  one-cycle pulse when payload byte missing at symbol boundary

Behaviour:
- Reset: state IDLE; symbol_in=2'b00, symbol_en=0, byte_ready=0, busy=0, done=0, underrun=0. Byte buffer is emptied and all counters are cleared.
- All outputs are registered. byte_ready is registered from the next-state/buffer values.
- States: IDLE, PREAMBLE, SYNC, LEN, PAYLOAD.
- IDLE + start (abort low): next cycle enter PREAMBLE with symbol_in=2'b00, symbol_en=1, busy=1. The first symbol lasts until the first mod_req and may be a partial period.
- Advance rule: symbol_in/symbol_en change only in the cycle after a mod_req=1 cycle. They hold otherwise. mod_req outside a frame is ignored.
- PREAMBLE: symbol k = 2'b00 for even k, 2'b10 for odd k. The mod_req after symbol PREAMBLE_LEN-1 moves to SYNC symbol 0.
- SYNC: symbols SYNC_WORD[15:14] down to [1:0]. The 8th mod_req moves to LEN.
- LEN: 4 symbols of the latched frame_len, MSB pair first.
- PAYLOAD: 4 symbols per byte, MSB pair first.
- Byte buffer: one-byte holding register plus a 2-bit symbol shifter.
  - byte_ready=1 iff busy, buffer empty, and bytes_fetched < latched length.
  - A transfer occurs on byte_valid&&byte_ready. The buffer is full from the next cycle.
  - Fetching may start in PREAMBLE.
- Byte boundary: at the mod_req ending LEN's last symbol or a byte's 4th symbol, with bytes remaining:
  - buffer full: load shifter, present its first symbol, buffer becomes empty;
  - buffer empty: next cycle state=IDLE, symbol_en=0, symbol_in=2'b00, underrun=1 for one cycle, no done.
- Frame end: at the mod_req ending the last symbol (the LEN 4th symbol if frame_len=0), next cycle state=IDLE, symbol_en=0, symbol_in=2'b00, busy=0, done=1 for one cycle.
- Total symbols per frame = PREAMBLE_LEN + 8 + 4 + 4*frame_len.
- Simultaneous events:
  - abort has priority over everything: next cycle IDLE, buffer emptied, no done/underrun pulse.
  - start while busy is ignored; frame_len changes while busy are ignored.
  - start and abort together in IDLE: stay IDLE.
  - mod_req coinciding with a byte handshake: the handshake byte is not visible in the buffer until the next cycle, so an empty buffer at that mod_req is an underrun.
- done and start in the same cycle: start is ignored, because the framer is not yet IDLE.
- Reset mid-frame: immediate return to reset values, asynchronously.

Test Plan:
- Normal frame: frame_len=2, bytes 8'h1B, 8'hE4 always valid, mod_req every 100 cycles.
  - Expect 32 alternating 00/10 symbols, then sync 10 10 01 01 11 00 00 11, then length 00 00 00 10, then payload 00 01 10 11 11 10 01 00.
  - done after the 52nd mod_req; symbol_en=0 the cycle after.
- Zero length: frame_len=0.
  - No byte_ready ever.
  - done after the 44th mod_req.
  - Start in the same cycle as done is ignored; start one cycle later is accepted.
- Underrun: frame_len=3, supply only 1 byte.
  - underrun pulses in the cycle after the 48th mod_req; symbol_en=0, busy=0, no done.
- Abort mid-sync: assert abort during SYNC symbol 3.
  - Next cycle IDLE, symbol_en=0, symbol_in=00, no done/underrun.
  - Buffer cleared: the next frame fetches a fresh first byte.
- Hold/pacing: mod_req spacing randomised 3..200 cycles, byte_valid random.
  - symbol_in is stable between mod_req pulses and changes exactly one cycle after each.
  - byte_ready never high with a full buffer.
- Async reset asserted during PAYLOAD: all outputs return to reset values without a clock edge; a frame started after release runs correctly.
